// File: rtl/divider_nr_param.sv
// Multi-cycle non-restoring integer divider, signed or unsigned per operation.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module divider_nr_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake: start is taken on any rising edge where the FSM is IDLE; busy is
  // high while an operation is in flight; done pulses for one cycle with q/r/dz
  // valid from then on, and it never overlaps busy.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic [CNT_W-1:0] cnt;
  logic             sq;
  logic             sr;
  logic             zero_div;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH:0]   fix_rem;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dvs_abs = dvs_neg ? -divisor : divisor;

  // The dropped top bit of the shift is harmless: the true result always fits WIDTH+1 bits.
  assign dvs_ext  = {1'b0, dvs_mag};
  assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign step_rem = rem[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
  assign fix_rem  = rem[WIDTH] ? (rem + dvs_ext) : rem;
  assign r_mag    = fix_rem[WIDTH-1:0];

  assign q_fin = zero_div ? '1 : (sq ? -quo : quo);
  assign r_fin = zero_div ? dvd_raw : (sr ? -r_mag : r_mag);

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = (divisor == '0) ? FIX : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      dvd_raw  <= '0;
      cnt      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      zero_div <= 1'b0;
      q        <= '0;
      r        <= '0;
      dz       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem      <= '0;
            quo      <= dvd_abs;
            dvs_mag  <= dvs_abs;
            dvd_raw  <= dividend;
            cnt      <= '0;
            sq       <= dvd_neg ^ dvs_neg;
            sr       <= dvd_neg;
            zero_div <= (divisor == '0);
          end
        end
        RUN: begin
          rem <= step_rem;
          quo <= {quo[WIDTH-2:0], ~step_rem[WIDTH]};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          q    <= q_fin;
          r    <= r_fin;
          dz   <= zero_div;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_nr_param.sv
// Self-checking bench for divider_nr_param: WIDTH=32 and WIDTH=8 instances against
// an arithmetic reference model; honours DIV_ZERO_FAST_EN for zero-divisor latency.
module tb_divider_nr_param;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;

  logic        start32, sop32;
  logic [31:0] dvd32, dvs32, q32, r32;
  logic        busy32, done32, dz32;

  logic        start8, sop8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        busy8, done8, dz8;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q32[$];
  logic [64:0] exp_q8[$];

  divider_nr_param #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .signed_op(sop32),
    .dividend(dvd32), .divisor(dvs32), .q(q32), .r(r32),
    .busy(busy32), .done(done32), .dz(dz32)
  );

  divider_nr_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_op(sop8),
    .dividend(dvd8), .divisor(dvs8), .q(q8), .r(r8),
    .busy(busy8), .done(done8), .dz(dz8)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model: returns {dz, q, r} with q/r zero-extended to 32 bits
  function automatic logic [64:0] model(input int w, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    longint mask = (longint'(1) << w) - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa, sb, eq, er;
    logic   edz;
    if (ub == 0) begin
      eq = mask; er = ua; edz = 1'b1;
    end else if (s) begin
      sa = ua[w-1] ? (ua - (longint'(1) << w)) : ua;
      sb = ub[w-1] ? (ub - (longint'(1) << w)) : ub;
      eq = (sa / sb) & mask;
      er = (sa % sb) & mask;
      edz = 1'b0;
    end else begin
      eq = ua / ub; er = ua % ub; edz = 1'b0;
    end
    return {edz, eq[31:0], er[31:0]};
  endfunction

  function automatic int exp_lat(input int w, input logic [31:0] b);
    logic [31:0] bm = (w == 32) ? b : {24'b0, b[7:0]};
    return (FAST && bm == 32'd0) ? 1 : w + 1;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return m;
      3:       return (m >> 1) + 32'd1;
      4:       return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // drivers: present an operation, let the accept edge pass, then scramble inputs
  task automatic start_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      start32 = 1'b1; sop32 = s; dvd32 = a; dvs32 = b;
      exp_q32.push_back(model(32, s, a, b));
    end else begin
      start8 = 1'b1; sop8 = s; dvd8 = a[7:0]; dvs8 = b[7:0];
      exp_q8.push_back(model(8, s, a, b));
    end
    @(posedge clock); #1;
    start32 = 1'b0; start8 = 1'b0;
    sop32 = 1'($urandom); dvd32 = $urandom; dvs32 = $urandom;
    sop8  = 1'($urandom); dvd8  = 8'($urandom); dvs8 = 8'($urandom);
  endtask

  task automatic wait_done(input int w, input int lat_exp, input string name);
    int lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clock); #1;
      if ((w == 32 && done32) || (w != 32 && done8)) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, 65'(lat), 65'(lat_exp));
  endtask

  // scoreboard compare: every done cycle is matched to the oldest accepted operation
  always @(negedge clock) begin
    if (!reset) begin
      if (done32) begin
        check("busy_low_at_done32", {64'b0, busy32}, 65'b0);
        if (exp_q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done32: got q=%h r=%h, expected no done", q32, r32);
        end else begin
          check("result32", {dz32, q32, r32}, exp_q32.pop_front());
        end
      end
      if (done8) begin
        check("busy_low_at_done8", {64'b0, busy8}, 65'b0);
        if (exp_q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done8: got q=%h r=%h, expected no done", q8, r8);
        end else begin
          check("result8", {dz8, 24'b0, q8, 24'b0, r8}, exp_q8.pop_front());
        end
      end
    end
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int done_cnt;
    int lat;
    logic [31:0] a, b;
    logic s;

    reset = 1'b1;
    start32 = 1'b0; sop32 = 1'b0; dvd32 = '0; dvs32 = '0;
    start8  = 1'b0; sop8  = 1'b0; dvd8  = '0; dvs8  = '0;

    // model pins
    check("pin_u100_7",   model(32, 1'b0, 32'd100, 32'd7),               {1'b0, 32'd14, 32'd2});
    check("pin_s-7_2",    model(32, 1'b1, 32'hFFFF_FFF9, 32'd2),         {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    check("pin_s7_-2",    model(32, 1'b1, 32'd7, 32'hFFFF_FFFE),         {1'b0, 32'hFFFF_FFFD, 32'd1});
    check("pin_uFFF9_2",  model(32, 1'b0, 32'hFFFF_FFF9, 32'd2),         {1'b0, 32'h7FFF_FFFC, 32'd1});
    check("pin_min_-1",   model(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 32'h8000_0000, 32'd0});
    check("pin_dz",       model(32, 1'b1, 32'h0000_1234, 32'd0),         {1'b1, 32'hFFFF_FFFF, 32'h0000_1234});

    repeat (3) @(posedge clock);
    #1;
    check("reset_flags32", {62'b0, busy32, done32, dz32}, 65'b0);
    check("reset_qr32",    {1'b0, q32, r32}, 65'b0);
    check("reset_flags8",  {62'b0, busy8, done8, dz8}, 65'b0);
    check("reset_qr8",     {49'b0, q8, r8}, 65'b0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // directed cases
    start_op(32, 1'b0, 32'd100, 32'd7);
    wait_done(32, 33, "u100_7");
    check("u100_7", {dz32, q32, r32}, {1'b0, 32'd14, 32'd2});
    repeat (3) @(posedge clock);
    #1;
    check("u100_7_hold", {dz32, q32, r32}, {1'b0, 32'd14, 32'd2});

    start_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(32, 33, "s-7_2");
    check("s-7_2", {dz32, q32, r32}, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});

    start_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(32, 33, "s7_-2");
    check("s7_-2", {dz32, q32, r32}, {1'b0, 32'hFFFF_FFFD, 32'd1});

    start_op(32, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(32, 33, "uFFF9_2");
    check("uFFF9_2", {dz32, q32, r32}, {1'b0, 32'h7FFF_FFFC, 32'd1});

    start_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32, 33, "min_-1");
    check("min_-1", {dz32, q32, r32}, {1'b0, 32'h8000_0000, 32'd0});

    start_op(32, 1'b0, 32'h0000_1234, 32'd0);
    wait_done(32, FAST ? 1 : 33, "dz_u");
    check("dz_u", {dz32, q32, r32}, {1'b1, 32'hFFFF_FFFF, 32'h0000_1234});

    start_op(32, 1'b1, 32'h0000_1234, 32'd0);
    wait_done(32, FAST ? 1 : 33, "dz_s");
    check("dz_s", {dz32, q32, r32}, {1'b1, 32'hFFFF_FFFF, 32'h0000_1234});

    // reset in the middle of an operation
    start_op(32, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q32.delete();
    exp_q8.delete();
    #1;
    check("midreset_flags", {62'b0, busy32, done32, dz32}, 65'b0);
    check("midreset_qr",    {1'b0, q32, r32}, 65'b0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    start_op(32, 1'b0, 32'd9, 32'd4);
    wait_done(32, 33, "after_reset_9_4");
    check("after_reset_9_4", {dz32, q32, r32}, {1'b0, 32'd2, 32'd1});

    // start pulses while busy are ignored
    start_op(32, 1'b0, 32'd50, 32'd5);
    done_cnt = 0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      start32 = (k == 5 || k == 20);
      if (start32) begin
        dvd32 = 32'd77; dvs32 = 32'd3;
      end
      @(posedge clock); #1;
      if (done32) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
      if (lat != 0 && k >= lat + 40) break;
    end
    start32 = 1'b0;
    check("busy_start_latency", 65'(lat), 65'd33);
    check("busy_start_single_done", 65'(done_cnt), 65'd1);
    check("busy_start_50_5", {dz32, q32, r32}, {1'b0, 32'd10, 32'd0});

    // back-to-back: second start issued in the done cycle
    start_op(32, 1'b0, 32'd1000, 32'd3);
    wait_done(32, 33, "b2b_first");
    start_op(32, 1'b1, 32'hFFFF_FC18, 32'd7);
    wait_done(32, 33, "b2b_second");
    check("b2b_second", {dz32, q32, r32}, {1'b0, 32'hFFFF_FF72, 32'hFFFF_FFFA});

    // randomised, WIDTH=32
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      s = 1'($urandom);
      a = pick(32);
      b = pick(32);
      start_op(32, s, a, b);
      wait_done(32, exp_lat(32, b), "rand32");
    end

    // randomised, WIDTH=8
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      s = 1'($urandom);
      a = pick(8);
      b = pick(8);
      start_op(8, s, a, b);
      wait_done(8, exp_lat(8, b), "rand8");
    end

    repeat (3) @(posedge clock);
    #1;
    check("queue32_drained", 65'(exp_q32.size()), 65'd0);
    check("queue8_drained",  65'(exp_q8.size()), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
